// File: rtl/accum_dump_mc.sv
// Multi-channel integrate-and-dump correlator accumulator with a held result
// register and a valid/ready handshake. The dump comes from an external strobe or an internal sample count.
module accum_dump_mc #(
  parameter int NCH   = 3,
  parameter int IN_W  = 3,
  parameter int ACC_W = 24,
  parameter int OUT_W = 17,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 mode,
  input  logic [CNT_W-1:0]     dump_len,
  input  logic                 dump_in,
  input  logic                 in_valid,
  input  logic [NCH*IN_W-1:0]  in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NCH*OUT_W-1:0] out_sum,
  output logic [CNT_W-1:0]     out_count,
  output logic [NCH-1:0]       out_sat,
  output logic                 overrun
);

  localparam logic signed [ACC_W:0]   ACC_MAX = {2'b00, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W:0]   ACC_MIN = -ACC_MAX;
  localparam logic signed [ACC_W-1:0] OUT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OUT_MIN = -OUT_MAX;

  logic signed [ACC_W-1:0] acc_q [NCH];
  logic signed [ACC_W-1:0] acc_d [NCH];
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [NCH*OUT_W-1:0]    sum_q, sum_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [NCH-1:0]          sat_q, sat_d;
  logic                    valid_q, valid_d;
  logic                    ovr_q, ovr_d;

  logic signed [ACC_W:0]   mag_ext [NCH];
  logic signed [ACC_W:0]   contrib [NCH];
  logic signed [ACC_W:0]   sum_ext [NCH];
  logic signed [ACC_W-1:0] acc_add [NCH];
  logic signed [ACC_W-1:0] res     [NCH];
  logic [NCH*OUT_W-1:0]    clip_sum;
  logic [NCH-1:0]          clip_sat;
  logic [CNT_W:0]          cnt_inc;
  logic [CNT_W:0]          len_eff;
  logic [CNT_W-1:0]        cnt_sat;
  logic                    dump_ev;

  always_comb begin
    cnt_inc  = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
    cnt_sat  = cnt_inc[CNT_W] ? '1 : cnt_inc[CNT_W-1:0];
    len_eff  = (dump_len == '0) ? {{CNT_W{1'b0}}, 1'b1} : {1'b0, dump_len};
    dump_ev  = mode ? (in_valid && (cnt_inc >= len_eff)) : dump_in;
    clip_sum = '0;
    clip_sat = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      mag_ext[k] = {{(ACC_W+2-IN_W){1'b0}}, in_data[k*IN_W +: IN_W-1]};
      contrib[k] = in_data[k*IN_W + IN_W-1] ? -mag_ext[k] : mag_ext[k];
      sum_ext[k] = {acc_q[k][ACC_W-1], acc_q[k]} + contrib[k];
      if (sum_ext[k] > ACC_MAX)      acc_add[k] = ACC_MAX[ACC_W-1:0];
      else if (sum_ext[k] < ACC_MIN) acc_add[k] = ACC_MIN[ACC_W-1:0];
      else                           acc_add[k] = sum_ext[k][ACC_W-1:0];
      // Internal-length dumps include the current sample; strobe dumps do not.
      res[k] = mode ? acc_add[k] : acc_q[k];
      if (res[k] > OUT_MAX) begin
        clip_sum[k*OUT_W +: OUT_W] = OUT_MAX[OUT_W-1:0];
        clip_sat[k]                = 1'b1;
      end else if (res[k] < OUT_MIN) begin
        clip_sum[k*OUT_W +: OUT_W] = OUT_MIN[OUT_W-1:0];
        clip_sat[k]                = 1'b1;
      end else begin
        clip_sum[k*OUT_W +: OUT_W] = res[k][OUT_W-1:0];
      end
    end
  end

  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    count_d = count_q;
    sat_d   = sat_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (clr) begin
      for (int unsigned k = 0; k < NCH; k++) acc_d[k] = '0;
      cnt_d   = '0;
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end else if (dump_ev) begin
      // A valid sample on a strobe dump seeds the next period.
      for (int unsigned k = 0; k < NCH; k++)
        acc_d[k] = (!mode && in_valid) ? contrib[k][ACC_W-1:0] : '0;
      cnt_d   = (!mode && in_valid) ? {{(CNT_W-1){1'b0}}, 1'b1} : '0;
      sum_d   = clip_sum;
      sat_d   = clip_sat;
      count_d = mode ? cnt_sat : cnt_q;
      valid_d = 1'b1;
      if (valid_q && !out_ready) ovr_d = 1'b1;
    end else begin
      if (in_valid) begin
        acc_d = acc_add;
        cnt_d = cnt_sat;
      end
      if (valid_q && out_ready) valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NCH; k++) acc_q[k] <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      count_q <= '0;
      sat_q   <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < NCH; k++) acc_q[k] <= acc_d[k];
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      count_q <= count_d;
      sat_q   <= sat_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign out_valid = valid_q;
  assign out_sum   = sum_q;
  assign out_count = count_q;
  assign out_sat   = sat_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_accum_dump_mc.sv
// Bench for accum_dump_mc: vector table, hand-written corner sequences and a
// randomized run checked against an integer reference model.
module tb_accum_dump_mc;
  localparam int NCH = 3, IN_W = 3, ACC_W = 24, OUT_W = 17, CNT_W = 16;
  localparam longint ACC_LIM = (64'sd1 <<< (ACC_W-1)) - 1;
  localparam longint OUT_LIM = (64'sd1 <<< (OUT_W-1)) - 1;
  localparam longint CNT_MAX = (64'sd1 <<< CNT_W) - 1;

  logic clk, rst_n, clr, mode, dump_in, in_valid, out_ready;
  logic [CNT_W-1:0] dump_len;
  logic [NCH*IN_W-1:0] in_data;
  logic out_valid, overrun;
  logic [NCH*OUT_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;
  logic [NCH-1:0] out_sat;

  int tests = 0, fails = 0;

  accum_dump_mc #(.NCH(NCH), .IN_W(IN_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .mode(mode), .dump_len(dump_len),
    .dump_in(dump_in), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_count(out_count), .out_sat(out_sat), .overrun(overrun));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model state
  longint macc [NCH];
  longint mcnt;
  longint msum [NCH];
  longint mcount;
  bit     msat [NCH];
  bit     mv, movr;

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic longint sum_ch(input int k);
    logic signed [OUT_W-1:0] v;
    v = out_sum[k*OUT_W +: OUT_W];
    return longint'(v);
  endfunction

  function automatic logic [IN_W-1:0] enc(input int v);
    logic [IN_W-1:0] r;
    r = (v < 0) ? IN_W'(-v) : IN_W'(v);
    r[IN_W-1] = (v < 0);
    return r;
  endfunction

  function automatic longint dec(input logic [IN_W-1:0] s);
    longint m;
    m = longint'(s[IN_W-2:0]);
    return s[IN_W-1] ? -m : m;
  endfunction

  function automatic longint clampl(input longint v, input longint lim);
    if (v > lim) return lim;
    if (v < -lim) return -lim;
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NCH; k++) begin
      macc[k] = 0; msum[k] = 0; msat[k] = 0;
    end
    mcnt = 0; mcount = 0; mv = 0; movr = 0;
  endtask

  task automatic model_step();
    longint c [NCH];
    longint r [NCH];
    longint rc, len;
    bit dump;
    if (clr) begin
      for (int k = 0; k < NCH; k++) macc[k] = 0;
      mcnt = 0; mv = 0; movr = 0;
      return;
    end
    for (int k = 0; k < NCH; k++) c[k] = dec(in_data[k*IN_W +: IN_W]);
    len  = (dump_len == 0) ? 1 : longint'(dump_len);
    dump = mode ? (in_valid && (mcnt + 1 >= len)) : dump_in;
    if (dump) begin
      if (mode) begin
        for (int k = 0; k < NCH; k++) begin
          r[k] = clampl(macc[k] + c[k], ACC_LIM); macc[k] = 0;
        end
        rc = (mcnt + 1 > CNT_MAX) ? CNT_MAX : mcnt + 1;
        mcnt = 0;
      end else begin
        for (int k = 0; k < NCH; k++) begin
          r[k] = macc[k]; macc[k] = in_valid ? c[k] : 0;
        end
        rc = mcnt;
        mcnt = in_valid ? 1 : 0;
      end
      for (int k = 0; k < NCH; k++) begin
        msum[k] = clampl(r[k], OUT_LIM);
        msat[k] = (msum[k] != r[k]);
      end
      mcount = rc;
      if (mv && !out_ready) movr = 1;
      mv = 1;
    end else begin
      if (in_valid) begin
        for (int k = 0; k < NCH; k++) macc[k] = clampl(macc[k] + c[k], ACC_LIM);
        mcnt = (mcnt + 1 > CNT_MAX) ? CNT_MAX : mcnt + 1;
      end
      if (mv && out_ready) mv = 0;
    end
  endtask

  task automatic drive(input logic c, input logic m, input logic [CNT_W-1:0] dl,
                       input logic di, input logic v, input logic [NCH*IN_W-1:0] d,
                       input logic rdy);
    clr = c; mode = m; dump_len = dl; dump_in = di; in_valid = v; in_data = d; out_ready = rdy;
  endtask

  // Model advances on the same inputs the DUT sees at the coming edge.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic clr, mode;
    logic [CNT_W-1:0] dl;
    logic din, vld;
    logic [NCH*IN_W-1:0] d;
    logic rdy;
    logic ev;
    int   es0;
    int   ec;
    logic eo;
  } vec_t;

  function automatic vec_t mk(input logic c, input logic m, input int dl, input logic di,
                              input logic v, input int s0, input logic rdy,
                              input logic ev, input int es0, input int ec, input logic eo);
    vec_t t;
    t.clr = c; t.mode = m; t.dl = CNT_W'(dl); t.din = di; t.vld = v;
    t.d = {{(NCH-1)*IN_W{1'b0}}, enc(s0)};
    t.rdy = rdy; t.ev = ev; t.es0 = es0; t.ec = ec; t.eo = eo;
    return t;
  endfunction

  vec_t tbl [19];
  int n;

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, '0, 0);
    model_reset();
    #12;
    chk("reset_valid", out_valid, 0);
    chk("reset_sum", out_sum, 0);
    chk("reset_count", out_count, 0);
    chk("reset_ovr", overrun, 0);
    rst_n = 1'b1;
    #3;

    // clr  mode dl din vld ch0 rdy | valid sum0 count ovr
    tbl[0]  = mk(1, 0, 0, 0, 0,  0, 1,  0,  0, 0, 0);
    tbl[1]  = mk(0, 1, 4, 0, 1,  3, 1,  0,  0, 0, 0);
    tbl[2]  = mk(0, 1, 4, 0, 1,  3, 1,  0,  0, 0, 0);
    tbl[3]  = mk(0, 1, 4, 0, 1, -1, 1,  0,  0, 0, 0);
    tbl[4]  = mk(0, 1, 4, 0, 1,  2, 1,  1,  7, 4, 0);
    tbl[5]  = mk(0, 1, 4, 0, 0,  0, 1,  0,  0, 0, 0);
    tbl[6]  = mk(1, 1, 2, 0, 0,  0, 0,  0,  0, 0, 0);
    tbl[7]  = mk(0, 1, 2, 0, 1,  1, 0,  0,  0, 0, 0);
    tbl[8]  = mk(0, 1, 2, 0, 1,  1, 0,  1,  2, 2, 0);
    tbl[9]  = mk(0, 1, 2, 0, 1,  2, 0,  1,  2, 2, 0);
    tbl[10] = mk(0, 1, 2, 0, 1,  2, 0,  1,  4, 2, 1);
    tbl[11] = mk(0, 1, 2, 0, 0,  0, 0,  1,  4, 2, 1);
    tbl[12] = mk(1, 1, 2, 0, 0,  0, 0,  0,  0, 0, 0);
    tbl[13] = mk(0, 1, 1, 0, 1,  1, 0,  1,  1, 1, 0);
    tbl[14] = mk(0, 1, 1, 0, 1,  3, 1,  1,  3, 1, 0);
    tbl[15] = mk(0, 1, 1, 0, 0,  0, 1,  0,  0, 0, 0);
    tbl[16] = mk(0, 1, 0, 0, 1, -2, 1,  1, -2, 1, 0);
    tbl[17] = mk(0, 0, 0, 1, 0,  0, 1,  1,  0, 0, 0);
    tbl[18] = mk(0, 0, 0, 0, 0,  0, 1,  0,  0, 0, 0);

    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].clr, tbl[i].mode, tbl[i].dl, tbl[i].din, tbl[i].vld, tbl[i].d, tbl[i].rdy);
      tick();
      chk($sformatf("tbl%0d_valid", i), out_valid, tbl[i].ev);
      chk($sformatf("tbl%0d_ovr", i), overrun, tbl[i].eo);
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_sum0", i), sum_ch(0), tbl[i].es0);
        chk($sformatf("tbl%0d_count", i), out_count, tbl[i].ec);
      end
    end

    // Strobe mode: dumping sample is carried into the next period
    drive(1, 0, 0, 0, 0, '0, 1); tick();
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 0, 1, {enc(0), enc(-2), enc(0)}, 1); tick();
    end
    drive(0, 0, 0, 1, 1, {enc(0), enc(-2), enc(0)}, 1); tick();
    chk("strobe_valid", out_valid, 1);
    chk("strobe_sum1", sum_ch(1), -10);
    chk("strobe_count", out_count, 5);
    drive(0, 0, 0, 1, 0, '0, 1); tick();
    chk("strobe_carry_sum1", sum_ch(1), -2);
    chk("strobe_carry_count", out_count, 1);

    // Long period: output clip while the accumulator stays in range
    drive(1, 1, 16'hFFFF, 0, 0, '0, 1); tick();
    drive(0, 1, 16'hFFFF, 0, 1, {enc(0) | 3'b100, enc(0), enc(3)}, 1);
    n = 0;
    while (!out_valid && n < 70000) begin
      tick();
      n++;
    end
    chk("long_cycles", n, 65535);
    chk("long_sum0", sum_ch(0), 65535);
    chk("long_sat0", out_sat[0], 1);
    chk("long_sum2", sum_ch(2), 0);
    chk("long_sat2", out_sat[2], 0);
    chk("long_count", out_count, 65535);

    // Asynchronous reset mid-period discards the partial period
    drive(1, 1, 2, 0, 0, '0, 0); tick();
    drive(0, 1, 2, 0, 1, {6'b0, enc(1)}, 0); tick(); tick();
    chk("rst_pre_valid", out_valid, 1);
    drive(0, 1, 2, 0, 1, {6'b0, enc(3)}, 0); tick();
    drive(0, 1, 2, 0, 0, '0, 0);
    rst_n = 1'b0;
    model_reset();
    #2;
    chk("rst_async_valid", out_valid, 0);
    chk("rst_async_sum", out_sum, 0);
    chk("rst_async_count", out_count, 0);
    #1 rst_n = 1'b1;
    drive(0, 1, 2, 0, 1, {6'b0, enc(1)}, 1); tick();
    chk("rst_post_idle", out_valid, 0);
    tick();
    chk("rst_post_valid", out_valid, 1);
    chk("rst_post_sum0", sum_ch(0), 2);
    chk("rst_post_count", out_count, 2);

    // Randomized run against the reference model
    drive(1, 0, 0, 0, 0, '0, 1); tick();
    for (int i = 0; i < 3000; i++) begin
      logic [NCH*OUT_W-1:0] es;
      logic [NCH-1:0] esat;
      drive(($urandom % 200) == 0, 1'($urandom % 2), CNT_W'($urandom % 6),
            ($urandom % 5) == 0, ($urandom % 4) != 0, (NCH*IN_W)'($urandom),
            1'($urandom % 2));
      tick();
      for (int k = 0; k < NCH; k++) begin
        es[k*OUT_W +: OUT_W] = OUT_W'(msum[k]);
        esat[k] = msat[k];
      end
      chk("rnd_valid", out_valid, mv);
      chk("rnd_ovr", overrun, movr);
      chk("rnd_sum", out_sum, es);
      chk("rnd_count", out_count, mcount);
      chk("rnd_sat", out_sat, esat);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
